// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX store controller.
package or1200_vlx_pkg;

  // IDLE: arbitrating, LSU: LSU owns store port, STORE: data byte out, STUFF: 0x00 pad after 0xFF
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LSU,
    ST_STORE,
    ST_STUFF
  } vlx_st_e;

  typedef enum logic {
    OWN_LSU,
    OWN_VLX
  } owner_e;

  localparam logic [7:0] VLX_STUFF_BYTE = 8'hFF;
  localparam logic [7:0] VLX_PAD_BYTE   = 8'h00;

endpackage

// File: rtl/or1200_vlx_store_ctrl_if.sv
// Packer, LSU arbitration and store-port signals of the VLX store controller.
interface or1200_vlx_store_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              flush_i;
  logic              addr_load_i;
  logic [ADDR_W-1:0] addr_i;
  logic [ADDR_W-1:0] addr_o;
  logic              lsu_req_i;
  logic              lsu_gnt_o;
  logic              st_req_o;
  logic [ADDR_W-1:0] st_addr_o;
  logic [7:0]        st_dat_o;
  logic              st_ack_i;
  logic              stall_cpu_o;
  logic              overflow_o;
  logic              addr_err_o;

  modport slave (
    input  byte_valid_i, byte_i, flush_i, addr_load_i, addr_i, lsu_req_i, st_ack_i,
    output byte_ready_o, addr_o, lsu_gnt_o, st_req_o, st_addr_o, st_dat_o,
           stall_cpu_o, overflow_o, addr_err_o
  );

  modport master (
    output byte_valid_i, byte_i, flush_i, addr_load_i, addr_i, lsu_req_i, st_ack_i,
    input  byte_ready_o, addr_o, lsu_gnt_o, st_req_o, st_addr_o, st_dat_o,
           stall_cpu_o, overflow_o, addr_err_o
  );

endinterface

// File: rtl/or1200_vlx_byte_fifo.sv
// DEPTH x 8 byte queue; a push while full is accepted only when a pop frees a slot the same cycle.
module or1200_vlx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_pop;
  logic             w_push;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign dout_o  = r_mem[r_rd_ptr];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/or1200_vlx_store_ctrl.sv
// Streams packed VLX bytes to the data-store port with JPEG 0xFF/0x00 stuffing,
// sharing the port with the CPU LSU by alternating priority.
module or1200_vlx_store_ctrl
  import or1200_vlx_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic clk_i,
  input logic rst_i,
  or1200_vlx_store_ctrl_if.slave bus
);

  vlx_st_e           r_state, w_state_nxt;
  owner_e            r_owner, w_owner_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_st_addr, w_st_addr_nxt;
  logic [7:0]        r_dat, w_dat_nxt;
  logic              r_flush, r_ovf, r_aerr;
  logic              w_pop, w_full, w_empty, w_flush_clr, w_ovf, w_aerr;
  logic [7:0]        w_head;

  or1200_vlx_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.byte_valid_i),
    .pop_i   (w_pop),
    .din_i   (bus.byte_i),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_addr_nxt    = r_addr;
    w_st_addr_nxt = r_st_addr;
    w_dat_nxt     = r_dat;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.addr_load_i && w_empty) w_addr_nxt = bus.addr_i;
        if (bus.lsu_req_i && (w_empty || r_owner == OWN_VLX)) begin
          w_state_nxt = ST_LSU;
        end else if (!w_empty) begin
          w_state_nxt   = ST_STORE;
          w_pop         = 1'b1;
          w_dat_nxt     = w_head;
          w_st_addr_nxt = r_addr;
        end
      end
      ST_LSU: begin
        if (!bus.lsu_req_i) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_LSU;
        end
      end
      ST_STORE, ST_STUFF: begin
        if (bus.st_ack_i) begin
          w_addr_nxt = r_addr + ADDR_W'(1);
          // The pad byte is never 0xFF, so STUFF can share the STORE exit path.
          if (r_state == ST_STORE && r_dat == VLX_STUFF_BYTE) begin
            w_state_nxt   = ST_STUFF;
            w_dat_nxt     = VLX_PAD_BYTE;
            w_st_addr_nxt = r_addr + ADDR_W'(1);
          end else if (!w_empty && !bus.lsu_req_i) begin
            w_state_nxt   = ST_STORE;
            w_pop         = 1'b1;
            w_dat_nxt     = w_head;
            w_st_addr_nxt = r_addr + ADDR_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_owner_nxt = OWN_VLX;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_flush_clr = w_empty && (w_state_nxt == ST_IDLE || w_state_nxt == ST_LSU);
  assign w_ovf       = bus.byte_valid_i && w_full && !w_pop;
  assign w_aerr      = bus.addr_load_i && !(r_state == ST_IDLE && w_empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_LSU;
      r_addr    <= '0;
      r_st_addr <= '0;
      r_dat     <= '0;
      r_flush   <= 1'b0;
      r_ovf     <= 1'b0;
      r_aerr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_addr    <= w_addr_nxt;
      r_st_addr <= w_st_addr_nxt;
      r_dat     <= w_dat_nxt;
      r_flush   <= (r_flush || bus.flush_i) && !w_flush_clr;
      r_ovf     <= r_ovf || w_ovf;
      r_aerr    <= w_aerr;
    end
  end

  assign bus.byte_ready_o = !w_full;
  assign bus.addr_o       = r_addr;
  assign bus.lsu_gnt_o    = (r_state == ST_LSU);
  assign bus.st_req_o     = (r_state == ST_STORE) || (r_state == ST_STUFF);
  assign bus.st_addr_o    = r_st_addr;
  assign bus.st_dat_o     = r_dat;
  assign bus.stall_cpu_o  = w_full || r_flush || (r_state == ST_STUFF);
  assign bus.overflow_o   = r_ovf;
  assign bus.addr_err_o   = r_aerr;

endmodule
